logic_unit_arbiter: RTL and testbench

//   Shares one 16-bit bitwise logic datapath (AND/OR/XOR/NOT lanes) between
//   N_REQ requesters. Grants one requester at a time by round-robin, latches its

---
 rtl/logic_unit_arbiter.sv | 177 +++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : Shares one bitwise logic datapath (AND / OR / XOR / NOT) between
//            N_REQ requesters. A round-robin arbiter picks one requester while
//            idle and latches its operands. The result is computed in one
//            registered cycle, and the tagged response is then held until the
//            consumer accepts it.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous, active-high; clears all state
//            req_valid  - per-requester request valid          [N_REQ]
//            req_ready  - per-requester accept, one-hot or zero [N_REQ]
//            req_op     - op of requester i at [2i+1:2i]
//            req_a      - operand a of requester i at [WIDTH*i +: WIDTH]
//            req_b      - operand b of requester i, same packing
//            rsp_valid  - response valid
//            rsp_ready  - consumer accepts the response
//            rsp_id     - index of the requester that owns rsp_data
//            rsp_data   - result
//            busy       - high whenever the unit is not idle
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  // Parameter sanity: reject unsupported configurations at elaboration.
  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_nreq
    $error("logic_unit_arbiter: N_REQ must be within 2..8");
  end
  if (IDW != $clog2(N_REQ)) begin : g_bad_idw
    $error("logic_unit_arbiter: IDW must equal clog2(N_REQ)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [IDW:0]     pick;
  logic             win_found;
  logic [IDW-1:0]   win_idx;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0, so the last match written is the one closest
  // to ptr, which gives first-match priority without an early exit.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                           input logic [IDW-1:0]   ptr);
    logic [31:0]  idx;
    logic [IDW:0] res;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % 32'(N_REQ);
      if (valid[idx[IDW-1:0]]) begin
        res = {1'b1, idx[IDW-1:0]};
      end
    end
    return res;
  endfunction

  // Shared bit-parallel datapath; op 11 is NOT a, and b is ignored.
  function automatic logic [WIDTH-1:0] lu_compute(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  assign pick      = rr_pick(req_valid, ptr_q);
  assign win_found = pick[IDW];
  assign win_idx   = pick[IDW-1:0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          // Ready is gated by reset because the asynchronous reset holds
          // the state in IDLE, where ready would otherwise be combinational.
          req_ready[win_idx] = ~reset;
          op_d    = req_op[2*win_idx +: 2];
          a_d     = req_a[WIDTH*win_idx +: WIDTH];
          b_d     = req_b[WIDTH*win_idx +: WIDTH];
          id_d    = win_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = lu_compute(op_q, a_q, b_q);
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Purpose  : Self-checking bench for logic_unit_arbiter. A transaction-level
//            reference model (grant scan from the pointer, three-phase
//            timing, result from the op table) predicts every output each
//            cycle. Directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic             busy;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting for a grant, 1 = computing,
  // 2 = response offered.
  int         m_phase;
  int         m_ptr;
  int         m_id;
  int         m_win;
  logic [W-1:0] m_data;
  int         grants[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic int find_winner();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N] === 1'b1) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // One clock cycle: inputs were applied at the preceding negedge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    #1;
    m_win     = (m_phase == 0) ? find_winner() : -1;
    exp_ready = '0;
    if (m_win >= 0) exp_ready[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
    end
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) grants.push_back(i);
    case (m_phase)
      0: if (m_win >= 0) begin
           m_id    = m_win;
           m_data  = ref_op(req_op[2*m_win +: 2], req_a[W*m_win +: W], req_b[W*m_win +: W]);
           m_phase = 1;
         end
      1: m_phase = 2;
      default: if (rsp_ready) begin
           m_phase = 0;
           m_ptr   = (m_id + 1) % N;
         end
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    m_phase = 0;
    m_ptr   = 0;
  endtask

  // Issue one request from requester i and check the result against a
  // hand-computed constant as well as the model.
  task automatic run_one(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
    bit done = 0;
    set_req(i, op, a, b);
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      if (m_phase == 2) begin
        chk("direct_data", 32'(rsp_data), 32'(exp));
        chk("direct_id", 32'(rsp_id), 32'(i));
        done = 1;
      end
      cycle();
      if (m_win == i) clr_req(i);
    end
    if (!done) chk("direct_timeout", 32'd0, 32'd1);
    clr_req(i);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_phase   = 0;
    m_ptr     = 0;
    m_id      = 0;
    m_win     = -1;
    m_data    = '0;
    @(negedge clk);
    // A valid request during reset must not be granted.
    req_valid[0] = 1'b1;
    do_reset();
    req_valid = '0;

    // Basic ops.
    run_one(0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000);
    run_one(1, 2'b10, 16'hAAAA, 16'hFFFF, 16'h5555);
    run_one(1, 2'b11, 16'h00FF, 16'h1234, 16'hFF00);
    run_one(1, 2'b01, 16'h1200, 16'h0034, 16'h1234);

    // All requesters continuously valid: rotation 0,1,2,3,0.
    do_reset();
    grants.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 16'h1111 * 16'(i + 1), 16'h0F0F);
    for (int c = 0; c < 15; c++) cycle();
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int g = 0; g < 5 && g < grants.size(); g++) chk("rr_order", 32'(grants[g]), 32'(g % N));
    req_valid = '0;
    while (m_phase != 0) cycle();

    // Backpressure with other requesters waiting.
    set_req(3, 2'b10, 16'h0FF0, 16'h00FF);
    rsp_ready = 1'b0;
    for (int c = 0; c < 10 && m_phase != 2; c++) begin
      cycle();
      if (m_win == 3) begin
        clr_req(3);
        set_req(0, 2'b00, 16'hFFFF, 16'h00AA);
        set_req(2, 2'b01, 16'h0001, 16'h0002);
      end
    end
    chk("bp_in_resp", 32'(m_phase), 32'd2);
    for (int c = 0; c < 5; c++) cycle();
    rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("bp_next_grant", 32'(m_win), 32'd0);
    req_valid = '0;
    while (m_phase != 0) cycle();

    // Asynchronous reset in the middle of EXEC.
    set_req(1, 2'b00, 16'hFFFF, 16'hFFFF);
    cycle();
    clr_req(1);
    chk("ar_in_exec", 32'(m_phase), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    m_phase = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 16'h0101, 16'h1010);
    #1;
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    while (m_phase != 0) cycle();

    // Wrap-around search with ptr=3 and only requester 2 valid.
    do_reset();
    run_one(2, 2'b00, 16'h00F0, 16'h0FF0, 16'h00F0);
    run_one(2, 2'b11, 16'h5A5A, 16'h0000, 16'hA5A5);
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 16'h0000, 16'h0000);
    #1;
    chk("wrap_ptr3", 32'(req_ready), 32'h8);
    cycle();
    req_valid = '0;
    while (m_phase != 0) cycle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0)
            set_req(i, 2'($urandom), 16'($urandom), 16'($urandom));
        end else if ($urandom_range(31) == 0) begin
          clr_req(i);
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
      cycle();
      if (m_win >= 0 && $urandom_range(3) != 0) clr_req(m_win);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
